// File: rtl/node_pwr_pkg.sv
// rtl/node_pwr_pkg.sv - shared states, default timing and bit-search helpers
package node_pwr_pkg;

  typedef enum logic [3:0] {
    ST_ALL_ON   = 4'h0,
    ST_STAGGER  = 4'h1,
    ST_SHUTDOWN = 4'h2,
    ST_WAIT_PG  = 4'h3,
    ST_ENABLE   = 4'h5,
    ST_SCAN     = 4'h7,
    ST_IDLE     = 4'h9,
    ST_FAULT    = 4'hf
  } state_t;

  localparam logic [15:0] STAGGER_MS_DEF    = 16'd20;
  localparam logic [15:0] PG_TIMEOUT_MS_DEF = 16'd150;

  // Both searches return 8 when no bit is set.
  function automatic logic [3:0] lowest_set(input logic [7:0] v);
    logic [3:0] idx;
    idx = 4'd8;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  function automatic logic [3:0] highest_set(input logic [7:0] v);
    logic [3:0] idx;
    idx = 4'd8;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/node_pwr_stagger_sched_timer.sv
// rtl/node_pwr_stagger_sched_timer.sv - saturating 1ms tick counter with limit compare
module node_tick_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        enable,
  input  logic        tick,
  input  logic [15:0] limit,
  output logic [15:0] count,
  output logic        expired
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && tick && (count != 16'hffff)) begin
      count <= count + 16'd1;
    end
  end

  assign expired = (count == limit);

endmodule

// File: rtl/node_pwr_stagger_sched.sv
// rtl/node_pwr_stagger_sched.sv - staggered power-up/down of node rails sharing one inrush budget
module node_pwr_stagger_sched
  import node_pwr_pkg::*;
#(
  parameter int          NUM_NODES     = 4,
  parameter logic [15:0] STAGGER_MS    = STAGGER_MS_DEF,
  parameter logic [15:0] PG_TIMEOUT_MS = PG_TIMEOUT_MS_DEF
) (
  input  logic                 iClk,
  input  logic                 iRst,
  input  logic                 iTick_1ms,
  input  logic                 iSeq_Go,
  input  logic [NUM_NODES-1:0] iNode_Mask,
  input  logic [NUM_NODES-1:0] iPWRGD_Node,
  output logic [NUM_NODES-1:0] oNode_EN,
  output logic                 oAll_On,
  output logic                 oBusy,
  output logic                 oFault,
  output logic [NUM_NODES-1:0] oFault_Node,
  output logic [3:0]           oDBG_FSM
);

  localparam logic [3:0] LAST_PTR = 4'(NUM_NODES);

  state_t               state, state_nxt;
  logic [3:0]           ptr, ptr_nxt, shut_ptr;
  logic [NUM_NODES-1:0] mask_q, node_en, ptr_bit, pg_bad, bad_first, fault_set, shut_rest;
  logic [NUM_NODES-1:0] fault_node_q;
  logic                 all_on_q, busy_q, fault_n_q;
  logic                 tmr_clear, tmr_enable, tmr_expired, tmr_done, shut_step;
  logic [15:0]          tmr_limit, tmr_count;

  always_comb begin
    ptr_bit   = '0;
    bad_first = '0;
    for (int i = 0; i < NUM_NODES; i++) begin
      ptr_bit[i]   = (ptr == 4'(i));
      bad_first[i] = (lowest_set(8'(pg_bad)) == 4'(i));
    end
  end

  assign pg_bad    = mask_q & node_en & ~iPWRGD_Node;
  assign shut_rest = node_en & ~ptr_bit;
  assign shut_ptr  = highest_set(8'(node_en));

  assign tmr_enable = (state == ST_WAIT_PG) || (state == ST_STAGGER) || (state == ST_SHUTDOWN);
  assign tmr_limit  = (state == ST_WAIT_PG) ? PG_TIMEOUT_MS : STAGGER_MS;
  assign tmr_clear  = (state_nxt != state) || shut_step;
  assign tmr_done   = tmr_expired || (tmr_count > tmr_limit);

  node_tick_timer u_timer (
    .clk     (iClk),
    .rst     (iRst),
    .clear   (tmr_clear),
    .enable  (tmr_enable),
    .tick    (iTick_1ms),
    .limit   (tmr_limit),
    .count   (tmr_count),
    .expired (tmr_expired)
  );

  // Fault checks come first in every state, then a dropped go, then progression.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    fault_set = '0;
    shut_step = 1'b0;
    case (state)
      ST_IDLE: begin
        if (iSeq_Go) begin
          ptr_nxt   = '0;
          state_nxt = (iNode_Mask == '0) ? ST_ALL_ON : ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (!iSeq_Go) begin
          state_nxt = ST_SHUTDOWN;
          ptr_nxt   = shut_ptr;
        end else if (ptr >= LAST_PTR) begin
          state_nxt = ST_ALL_ON;
        end else if (|(mask_q & ptr_bit)) begin
          state_nxt = ST_ENABLE;
        end else begin
          ptr_nxt = ptr + 4'd1;
        end
      end
      ST_ENABLE: begin
        if (!iSeq_Go) begin
          state_nxt = ST_SHUTDOWN;
          ptr_nxt   = shut_ptr;
        end else begin
          state_nxt = ST_WAIT_PG;
        end
      end
      ST_WAIT_PG: begin
        if (tmr_done) begin
          state_nxt = ST_FAULT;
          fault_set = ptr_bit;
        end else if (!iSeq_Go) begin
          state_nxt = ST_SHUTDOWN;
          ptr_nxt   = shut_ptr;
        end else if (|(iPWRGD_Node & ptr_bit)) begin
          state_nxt = ST_STAGGER;
        end
      end
      ST_STAGGER: begin
        if (!iSeq_Go) begin
          state_nxt = ST_SHUTDOWN;
          ptr_nxt   = shut_ptr;
        end else if (tmr_done) begin
          state_nxt = ST_SCAN;
          ptr_nxt   = ptr + 4'd1;
        end
      end
      ST_ALL_ON: begin
        if (pg_bad != '0) begin
          state_nxt = ST_FAULT;
          fault_set = bad_first;
        end else if (!iSeq_Go) begin
          state_nxt = ST_SHUTDOWN;
          ptr_nxt   = shut_ptr;
        end
      end
      ST_SHUTDOWN: begin
        if (node_en == '0) begin
          state_nxt = ST_IDLE;
        end else if (tmr_done) begin
          if (shut_rest == '0) begin
            state_nxt = ST_IDLE;
          end else begin
            ptr_nxt   = highest_set(8'(shut_rest));
            shut_step = 1'b1;
          end
        end
      end
      ST_FAULT: begin
        if (!iSeq_Go) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state        <= ST_IDLE;
      ptr          <= '0;
      mask_q       <= '0;
      node_en      <= '0;
      all_on_q     <= 1'b0;
      busy_q       <= 1'b0;
      fault_n_q    <= 1'b1;
      fault_node_q <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      if ((state == ST_IDLE) && iSeq_Go) mask_q <= iNode_Mask;
      if (state_nxt == ST_FAULT) begin
        node_en <= '0;
      end else if ((state == ST_ENABLE) && (state_nxt == ST_WAIT_PG)) begin
        node_en <= node_en | ptr_bit;
      end else if (state == ST_SHUTDOWN) begin
        node_en <= node_en & ~ptr_bit;
      end
      all_on_q  <= (state_nxt == ST_ALL_ON);
      busy_q    <= state_nxt inside {ST_SCAN, ST_ENABLE, ST_WAIT_PG, ST_STAGGER, ST_SHUTDOWN};
      fault_n_q <= (state_nxt != ST_FAULT);
      if (state_nxt != ST_FAULT) begin
        fault_node_q <= '0;
      end else if (state != ST_FAULT) begin
        fault_node_q <= fault_set;
      end
    end
  end

  assign oNode_EN    = node_en;
  assign oAll_On     = all_on_q;
  assign oBusy       = busy_q;
  assign oFault      = fault_n_q;
  assign oFault_Node = fault_node_q;
  assign oDBG_FSM    = state;

endmodule

// File: tb/tb_node_pwr_stagger_sched.sv
// tb/tb_node_pwr_stagger_sched.sv - directed vectors and corner sequences for the stagger scheduler
module tb_node_pwr_stagger_sched;

  localparam int N = 4;

  typedef struct {
    logic [3:0] mask;
    logic [3:0] never;
    logic [3:0] exp_en;
    logic       exp_all_on;
    logic       exp_fault;
    logic [3:0] exp_fnode;
    logic [3:0] exp_dbg;
    int         exp_ticks;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst, tick, go;
  logic [N-1:0] mask, pwrgd, en, fnode, pg_raw, pg_never, pg_kill, en_prev;
  logic         all_on, busy, fault_n;
  logic [3:0]   dbg;

  int errors = 0;
  int checks = 0;
  int since_rise, since_fall, fall_cnt, phase, zero_gen, zero_seen;
  int rise_gap[N], fall_gap[N], fall_rank[N], pg_cnt[N];
  vec_t vecs[6];
  bit ok;

  assign pwrgd = pg_raw & ~pg_never & ~pg_kill;

  always #5 clk = ~clk;

  node_pwr_stagger_sched dut (
    .iClk        (clk),
    .iRst        (rst),
    .iTick_1ms   (tick),
    .iSeq_Go     (go),
    .iNode_Mask  (mask),
    .iPWRGD_Node (pwrgd),
    .oNode_EN    (en),
    .oAll_On     (all_on),
    .oBusy       (busy),
    .oFault      (fault_n),
    .oFault_Node (fnode),
    .oDBG_FSM    (dbg)
  );

  // Tick source every 8 clocks, rails that go good 5 ticks after enable, edge spacing in ticks.
  initial begin
    tick = 1'b0; phase = 0; pg_raw = '0; en_prev = '0;
    since_rise = 0; since_fall = 0; fall_cnt = 0; zero_seen = 0;
    for (int i = 0; i < N; i++) begin
      pg_cnt[i] = 0; rise_gap[i] = -1; fall_gap[i] = -1; fall_rank[i] = -1;
    end
    forever begin
      @(negedge clk);
      if (zero_seen != zero_gen) begin
        zero_seen = zero_gen; since_rise = 0; since_fall = 0; fall_cnt = 0;
      end
      if (tick) begin since_rise++; since_fall++; end
      for (int i = 0; i < N; i++) begin
        if (!en[i]) pg_cnt[i] = 0;
        else if (tick && pg_cnt[i] < 5) pg_cnt[i]++;
        pg_raw[i] = (pg_cnt[i] >= 5);
        if (en[i] && !en_prev[i]) rise_gap[i] = since_rise;
        if (!en[i] && en_prev[i]) begin
          fall_gap[i] = since_fall; fall_rank[i] = fall_cnt; fall_cnt++;
        end
      end
      if ((en & ~en_prev) != '0) since_rise = 0;
      if ((~en & en_prev) != '0) since_fall = 0;
      en_prev = en;
      tick = (phase == 0);
      phase = (phase + 1) % 8;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting on DUT", name);
  endtask

  task automatic do_reset();
    rst = 1'b1; go = 1'b0; pg_never = '0; pg_kill = '0;
    repeat (2) step();
    rst = 1'b0;
    step();
  endtask

  task automatic align_and_go(input logic lvl);
    do @(posedge clk); while (tick !== 1'b1);
    step();
    go = lvl;
    zero_gen++;
  endtask

  task automatic wait_settle(output bit done);
    done = 1'b0;
    for (int k = 0; k < 3000 && !done; k++) begin
      step();
      if (all_on || !fault_n) done = 1'b1;
    end
  endtask

  task automatic wait_idle(output bit done);
    done = 1'b0;
    for (int k = 0; k < 3000 && !done; k++) begin
      step();
      if (dbg == 4'h9) done = 1'b1;
    end
  endtask

  task automatic power_up(input logic [3:0] m, input logic [3:0] nv, output bit done);
    do_reset();
    pg_never = nv;
    mask = m;
    align_and_go(1'b1);
    step();
    mask = ~m;
    wait_settle(done);
  endtask

  initial begin
    vecs[0] = '{4'b1111, 4'b0000, 4'b1111, 1'b1, 1'b1, 4'b0000, 4'h0, 25};
    vecs[1] = '{4'b0101, 4'b0000, 4'b0101, 1'b1, 1'b1, 4'b0000, 4'h0, 25};
    vecs[2] = '{4'b0011, 4'b0010, 4'b0000, 1'b0, 1'b0, 4'b0010, 4'hf, 150};
    vecs[3] = '{4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1, 4'b0000, 4'h0, 0};
    vecs[4] = '{4'b1000, 4'b0000, 4'b1000, 1'b1, 1'b1, 4'b0000, 4'h0, 25};
    vecs[5] = '{4'b1111, 4'b0001, 4'b0000, 1'b0, 1'b0, 4'b0001, 4'hf, 150};

    zero_gen = 0; rst = 1'b1; go = 1'b0; mask = '0; pg_never = '0; pg_kill = '0;
    step();
    chk("reset en", en, 4'b0000);
    chk("reset all_on", all_on, 1'b0);
    chk("reset busy", busy, 1'b0);
    chk("reset fault", fault_n, 1'b1);
    chk("reset fnode", fnode, 4'b0000);
    chk("reset dbg", dbg, 4'h9);

    for (int v = 0; v < 6; v++) begin
      power_up(vecs[v].mask, vecs[v].never, ok);
      if (!ok) timeout($sformatf("v%0d settle", v));
      chk($sformatf("v%0d en", v), en, vecs[v].exp_en);
      chk($sformatf("v%0d all_on", v), all_on, vecs[v].exp_all_on);
      chk($sformatf("v%0d fault", v), fault_n, vecs[v].exp_fault);
      chk($sformatf("v%0d fnode", v), fnode, vecs[v].exp_fnode);
      chk($sformatf("v%0d busy", v), busy, 1'b0);
      chk($sformatf("v%0d dbg", v), dbg, vecs[v].exp_dbg);
      chk($sformatf("v%0d ticks", v), since_rise, vecs[v].exp_ticks);
      align_and_go(1'b0);
      wait_idle(ok);
      if (!ok) timeout($sformatf("v%0d idle", v));
      chk($sformatf("v%0d idle en", v), en, 4'b0000);
      chk($sformatf("v%0d idle fault", v), fault_n, 1'b1);
      chk($sformatf("v%0d idle fnode", v), fnode, 4'b0000);
      chk($sformatf("v%0d idle busy", v), busy, 1'b0);
    end

    // Full up then full down: rise spacing 25 ticks, falls in reverse order 20 ticks apart.
    power_up(4'b1111, 4'b0000, ok);
    if (!ok) timeout("updown settle");
    for (int i = 1; i < N; i++) chk($sformatf("rise gap %0d", i), rise_gap[i], 25);
    align_and_go(1'b0);
    step();
    chk("shutdown busy", busy, 1'b1);
    chk("shutdown dbg", dbg, 4'h2);
    chk("shutdown all_on", all_on, 1'b0);
    wait_idle(ok);
    if (!ok) timeout("shutdown idle");
    for (int i = 0; i < N - 1; i++) chk($sformatf("fall gap %0d", i), fall_gap[i], 20);
    for (int i = 0; i < N; i++) chk($sformatf("fall rank %0d", i), fall_rank[i], N - 1 - i);
    chk("shutdown end busy", busy, 1'b0);

    // Power-good loss on node 2 in the same cycle go drops: fault wins.
    power_up(4'b1111, 4'b0000, ok);
    if (!ok) timeout("pgloss settle");
    chk("pgloss pre en", en, 4'b1111);
    pg_kill = 4'b0100;
    go = 1'b0;
    step();
    chk("pgloss en", en, 4'b0000);
    chk("pgloss fault", fault_n, 1'b0);
    chk("pgloss fnode", fnode, 4'b0100);
    chk("pgloss dbg", dbg, 4'hf);
    step();
    chk("pgloss idle dbg", dbg, 4'h9);
    chk("pgloss idle fault", fault_n, 1'b1);
    chk("pgloss idle fnode", fnode, 4'b0000);

    // Asynchronous reset while staggering with two rails up.
    do_reset();
    mask = 4'b1111;
    align_and_go(1'b1);
    ok = 1'b0;
    for (int k = 0; k < 3000 && !ok; k++) begin
      step();
      if (en == 4'b0011 && dbg == 4'h1) ok = 1'b1;
    end
    if (!ok) timeout("stagger reach");
    chk("prerst busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("arst en", en, 4'b0000);
    chk("arst all_on", all_on, 1'b0);
    chk("arst busy", busy, 1'b0);
    chk("arst fault", fault_n, 1'b1);
    chk("arst fnode", fnode, 4'b0000);
    chk("arst dbg", dbg, 4'h9);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/node_pwr_stagger_sched.md
Name: node_pwr_stagger_sched

Overview:
- Schedules the staggered power-on and power-off of up to NUM_NODES P12V node rails that share one inrush budget.
- Sits between the master power sequencer and the per-node rail enables. One go/stop level comes in; node enables go out one at a time, spaced by a fixed interval.
- Each enable must see its power-good within a timeout. The block reports completion and latches any fault.

Parameters:
NUM_NODES, 4, number of node rails scheduled (1..8)
STAGGER_MS, 16'd20, minimum iTick_1ms count between successive enable edges (on or off)
PG_TIMEOUT_MS, 16'd150, iTick_1ms count allowed from enable assertion to power-good

Ports:
iClk  in  1  module clock, 2MHz
iRst  in  1  asynchronous active-high reset
iTick_1ms  in  1  single-iClk-cycle strobe every 1ms, synchronous to iClk
iSeq_Go  in  1  level from master sequencer; 1 = power nodes up, 0 = power nodes down
iNode_Mask  in  NUM_NODES  1 = node populated and scheduled; sampled only in IDLE
iPWRGD_Node  in  NUM_NODES  per-node rail power-good (already synchronised)
oNode_EN  out  NUM_NODES  per-node rail enable
oAll_On  out  1  all masked nodes enabled and good
oBusy  out  1  stagger sequence in progress (up or down)
oFault  out  1  active-low fault flag; 0 = fault latched
oFault_Node  out  NUM_NODES  one-hot index of the first faulting node
oDBG_FSM  out  4  current state encoding

Behaviour:
- Reset (asynchronous, iRst=1):
  - oNode_EN=0, oAll_On=0, oBusy=0, oFault=1, oFault_Node=0, oDBG_FSM=IDLE.
  - Pointer=0, timer=0, latched mask=0.
- Timer: 16-bit counter. Cleared to 0 on every state entry. Increments on each iTick_1ms in timed states. Expiry when count==limit. A limit of 0 expires on the first cycle in the state. The counter saturates and never wraps.
- States (encodings): IDLE 4'h9, SCAN 4'h7, ENABLE 4'h5, WAIT_PG 4'h3, STAGGER 4'h1, ALL_ON 4'h0, SHUTDOWN 4'h2, FAULT 4'hf.
- IDLE:
  - When iSeq_Go=1, latch iNode_Mask, set pointer=0, go to SCAN.
  - If the latched mask is all-zero, go directly to ALL_ON.
- SCAN:
  - Advance the pointer to the lowest index >= pointer with mask=1. This takes one cycle per skipped index.
  - A set bit goes to ENABLE. Pointer==NUM_NODES goes to ALL_ON.
- ENABLE: set oNode_EN[pointer]=1 this cycle, then go to WAIT_PG.
- WAIT_PG:
  - iPWRGD_Node[pointer]=1 goes to STAGGER.
  - Timer==PG_TIMEOUT_MS goes to FAULT with oFault_Node[pointer]=1.
- STAGGER: when the timer reaches STAGGER_MS, pointer+1, then go to SCAN.
- ALL_ON:
  - oAll_On=1.
  - Any masked node with oNode_EN=1 and iPWRGD_Node=0 goes to FAULT. oFault_Node is set to the lowest such index.
- SHUTDOWN:
  - Entered from SCAN, ENABLE, WAIT_PG, STAGGER or ALL_ON whenever iSeq_Go=0. In the same cycle oAll_On=0 and the pointer is set to the highest enabled index.
  - Clear oNode_EN[pointer], wait STAGGER_MS ticks, then step to the next-lower enabled index.
  - When no enable remains, go to IDLE.
  - Nodes are disabled in reverse order of enabling.
- FAULT:
  - All oNode_EN cleared in the entry cycle, with no stagger. oFault=0.
  - oFault and oFault_Node hold until iSeq_Go=0, then go to IDLE and clear both.
  - iSeq_Go held at 1 keeps FAULT; it never retries automatically.
- Priority in a single cycle, highest first: FAULT detection, then iSeq_Go=0 (SHUTDOWN), then normal progression. A power-good loss and iSeq_Go falling in the same cycle go to FAULT.
- oBusy=1 in SCAN, ENABLE, WAIT_PG, STAGGER and SHUTDOWN.
- Outputs are registered. An enable edge appears one iClk after the state decision.
- Changes to iNode_Mask outside IDLE are ignored.

Decomposition:
- Shared package node_pwr_pkg holds:
  - the state localparams;
  - the default STAGGER_MS and PG_TIMEOUT_MS values;
  - a function for the lowest/highest set bit from a NUM_NODES vector.
- One sub-module, node_tick_timer: clear, enable, tick, limit in; count and expired out. Reused for the stagger and timeout phases.

Test Plan:
1. Mask=4'b1111, power-good follows enable after 5 ticks, iSeq_Go=1 -> EN0..EN3 rise in order. Enable edges are spaced 25 ticks apart (5 power-good + 20 stagger). oAll_On=1 after EN3 is good; oBusy=0.
2. Mask=4'b0101 -> only EN0 and EN2 assert. EN1 and EN3 stay 0. oAll_On=1.
3. Mask=4'b0011, node1 power-good never rises -> at tick 150 after EN1: oFault=0, oFault_Node=4'b0010, all EN=0. Dropping iSeq_Go returns to IDLE with oFault=1.
4. ALL_ON with mask 4'b1111, then iSeq_Go=0 -> EN3, EN2, EN1, EN0 fall 20 ticks apart. IDLE is reached with oBusy=0.
5. ALL_ON, then iPWRGD_Node[2] drops in the same cycle iSeq_Go falls -> FAULT wins, oFault_Node=4'b0100, all EN drop in one cycle.
6. Assert iRst while in STAGGER with EN0 and EN1 high -> all outputs go to reset values immediately, asynchronously to iClk.
